int_ctrl: RTL and testbench
===========================

# int_ctrl

Prioritised interrupt controller that collects edge-triggered events from up to NUM_SOURCES peripheral lines and serialises them onto the execution unit's single int_req/int_ack handshake. It sits beside the memory/IO mux in cpu_top: its outputs drive exec_unit.int_req, and it consumes exec_unit.int_ack. Software programs the mask register and signals end-of-interrupt through write strobes decoded by the mux. Software reads the status outputs through the same mux.

## Interface
- NUM_SOURCES, 4: number of interrupt inputs (2..8); index 0 has the highest priority.
- ID_BITS, $clog2(NUM_SOURCES): width of the active source id.

- clk  in  1: single system clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- irq_src  in  NUM_SOURCES: raw asynchronous event lines; a rising edge is one event.
- mask_wr_en  in  1: loads mask_wr_data into the mask register.
- mask_wr_data  in  NUM_SOURCES: 1 = source enabled.
- eoi_en  in  1: end-of-interrupt strobe from software.
- int_ack  in  1: acknowledge from the execution unit.
- int_req  out  1: interrupt request to the execution unit; registered.
- active_valid  out  1: a source is being requested or serviced.
- active_id  out  ID_BITS: id of the source being requested or serviced.
- pending  out  NUM_SOURCES: latched, not-yet-acknowledged events; masked bits included.
- mask  out  NUM_SOURCES: current mask register.

## Operation
- Reset values: int_req=0, active_valid=0, active_id=0, pending=0, mask=0 (all sources disabled), FSM=IDLE, synchroniser flops=0.
- Each irq_src bit passes through a 2-flop synchroniser and then a delay flop.
- An event is sync2=1 & delayed=0. An event sets the pending bit regardless of mask.
- Eligible sources = pending & mask. The winner is the lowest eligible index.
- FSM IDLE:
  - If any source is eligible, latch the winner into active_id.
  - Set active_valid=1 and int_req=1, then go to REQUEST.
  - int_ack and eoi_en are ignored in IDLE.
- FSM REQUEST:
  - Hold int_req=1 until int_ack is sampled high.
  - On that edge: int_req=0, clear pending[active_id], go to SERVICE.
  - A mask write that disables active_id does not withdraw the request.
  - eoi_en is ignored in REQUEST.
- FSM SERVICE:
  - int_req=0 throughout.
  - On eoi_en: active_valid=0, go to IDLE. active_id keeps its last value.
  - int_ack is ignored in SERVICE.
  - Only one interrupt is in service at a time; there is no nesting.
- Simultaneous events:
  - Clear and a new event on the same pending bit in the same cycle: the set wins, so the new event is retained.
  - Multiple events in one cycle are all latched.
  - A repeated event on an already-pending bit is merged (no count).
- The mask write takes effect from the next edge. Eligibility in the same cycle uses the old mask.
- When eoi_en arrives and another source is eligible: IDLE is visited for exactly one cycle, then arbitration re-runs.

## Timing
- irq_src rising edge first sampled at edge k:
  - sync1=1 at k
  - sync2=1 at k+1
  - pending set at k+2
  - int_req=1 after k+3
- Event-to-request latency is 3 cycles when IDLE.
- int_ack sampled high at edge m: int_req=0 and pending bit cleared after m.
- eoi_en sampled at edge n: active_valid=0 after n.
  - The earliest next int_req is after n+1.
- Asynchronous reset asserted mid-REQUEST or mid-SERVICE: all state returns to reset values immediately. Events in flight are lost.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- int_ctrl_pkg holds:
  - the FSM enum: IDLE, REQUEST, SERVICE
  - the default NUM_SOURCES constant
  - a priority-encode function (lowest set bit to id)
- One sub-module, irq_edge_sync: per-bit 2-flop synchroniser plus delay flop, emitting a one-cycle event pulse. Instantiated with width NUM_SOURCES.
- In cpu_top, memory_io_mux gains decode for the mask and EOI addresses and a read-back of {active_valid, active_id, pending}.

## Test plan
- Reset, then mask=4'b0001, pulse irq_src[0] -> pending=0001 at k+2; int_req=1 and active_id=0 after k+3; int_ack -> int_req=0, pending=0000; eoi_en -> active_valid=0.
- mask=4'b1111, rising edges on irq_src[3] and irq_src[1] in the same cycle -> active_id=1 first. After ack and eoi: one IDLE cycle, then active_id=3 and int_req=1.
- mask=0, pulse irq_src[2] -> pending=0100, int_req stays 0. Write mask=0100 -> int_req=1 with active_id=2 two edges after the write.
- irq_src[0] re-edges exactly on the int_ack edge for source 0 -> pending[0] remains 1. After eoi, a second request for id 0 follows.
- Assert reset during SERVICE with pending=0110 -> int_req=0, active_valid=0, pending=0, mask=0 immediately. No request after release until a new edge arrives and the mask is written.
- int_ack pulsed in IDLE and eoi_en pulsed in REQUEST -> no state change. int_req held until a real ack arrives.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
package int_ctrl_pkg;

  localparam int DEFAULT_NUM_SOURCES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Lowest set bit wins; callers zero-extend narrower vectors to 8 bits.
  function automatic logic [2:0] prio_enc(input logic [7:0] vec);
    prio_enc = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) prio_enc = 3'(i);
    end
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Software/execution-unit facing signals of int_ctrl, grouped for port binding.
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int ID_BITS     = $clog2(NUM_SOURCES)
);
  logic [NUM_SOURCES-1:0] irq_src;
  logic                   mask_wr_en;
  logic [NUM_SOURCES-1:0] mask_wr_data;
  logic                   eoi_en;
  logic                   int_ack;
  logic                   int_req;
  logic                   active_valid;
  logic [ID_BITS-1:0]     active_id;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] mask;

  modport master (
    output irq_src, mask_wr_en, mask_wr_data, eoi_en, int_ack,
    input  int_req, active_valid, active_id, pending, mask
  );

  modport slave (
    input  irq_src, mask_wr_en, mask_wr_data, eoi_en, int_ack,
    output int_req, active_valid, active_id, pending, mask
  );
endinterface

// File: rtl/int_ctrl_irq_edge_sync.sv
// Per-bit 2-flop synchroniser plus delay flop; emits a one-cycle pulse per rising edge.
module irq_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pulse
);
  logic [WIDTH-1:0] sync1, sync2, delayed;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      delayed <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      delayed <= sync2;
    end
  end

  assign pulse = sync2 & ~delayed;
endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: latches edge events and serialises them onto int_req/int_ack.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int ID_BITS     = $clog2(NUM_SOURCES)
) (
  input  logic       clk,
  input  logic       reset,
  int_ctrl_if.slave  bus
);
  logic [NUM_SOURCES-1:0] evt;
  logic [NUM_SOURCES-1:0] eligible, clr;
  logic [NUM_SOURCES-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [ID_BITS-1:0]     id_q, id_d;
  logic                   int_req_q, int_req_d, valid_q, valid_d;
  state_e                 state, state_next;

  irq_edge_sync #(.WIDTH(NUM_SOURCES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.irq_src),
    .pulse (evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    int_req_d  = int_req_q;
    valid_d    = valid_q;
    id_d       = id_q;
    clr        = '0;
    eligible   = pend_q & mask_q;

    unique case (state)
      IDLE: begin
        if (|eligible) begin
          id_d       = ID_BITS'(prio_enc(8'(eligible)));
          valid_d    = 1'b1;
          int_req_d  = 1'b1;
          state_next = REQUEST;
        end
      end
      // The request is committed: later mask writes do not withdraw it.
      REQUEST: begin
        if (bus.int_ack) begin
          int_req_d  = 1'b0;
          clr        = NUM_SOURCES'(1) << id_q;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi_en) begin
          valid_d    = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new event on the bit being cleared is kept: set wins over clear.
    pend_d = (pend_q & ~clr) | evt;
    mask_d = bus.mask_wr_en ? bus.mask_wr_data : mask_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_req_q <= 1'b0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
    end else begin
      int_req_q <= int_req_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.int_req      = int_req_q;
  assign bus.active_valid = valid_q;
  assign bus.active_id    = id_q;
  assign bus.pending      = pend_q;
  assign bus.mask         = mask_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;
  localparam int N = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int_ctrl_if #(.NUM_SOURCES(N)) bus ();

  int_ctrl #(.NUM_SOURCES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then show the post-edge state.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    bus.mask_wr_data = m;
    bus.mask_wr_en   = 1'b1;
    tick();
    bus.mask_wr_en   = 1'b0;
  endtask

  task automatic do_ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.eoi_en = 1'b1;
    tick();
    bus.eoi_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.irq_src = '0; bus.mask_wr_en = 1'b0; bus.mask_wr_data = '0;
    bus.eoi_en = 1'b0; bus.int_ack = 1'b0;
    tick(2);
    checks++;
    if ({bus.int_req, bus.active_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_req_valid: got %b exp 00", {bus.int_req, bus.active_valid});
    end
    checks++;
    if (bus.active_id !== 2'd0) begin
      errors++; $display("FAIL reset_id: got %0d exp 0", bus.active_id);
    end
    checks++;
    if ({bus.pending, bus.mask} !== 8'h00) begin
      errors++; $display("FAIL reset_pend_mask: got %b exp 00000000", {bus.pending, bus.mask});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    write_mask(4'b0001);
    checks++;
    if (bus.mask !== 4'b0001) begin
      errors++; $display("FAIL basic_mask: got %b exp 0001", bus.mask);
    end
    bus.irq_src = 4'b0001;
    tick(2);  // edges k, k+1
    checks++;
    if (bus.pending !== 4'b0000) begin
      errors++; $display("FAIL basic_pend_early: got %b exp 0000", bus.pending);
    end
    tick();   // k+2
    checks++;
    if ({bus.pending, bus.int_req} !== 5'b0001_0) begin
      errors++; $display("FAIL basic_pend_k2: got %b exp 00010", {bus.pending, bus.int_req});
    end
    tick();   // k+3
    bus.irq_src = '0;
    checks++;
    if ({bus.int_req, bus.active_valid, bus.active_id} !== 4'b11_00) begin
      errors++; $display("FAIL basic_req_k3: got %b exp 1100", {bus.int_req, bus.active_valid, bus.active_id});
    end
    do_ack();
    checks++;
    if ({bus.int_req, bus.pending} !== 5'b0_0000) begin
      errors++; $display("FAIL basic_ack: got %b exp 00000", {bus.int_req, bus.pending});
    end
    do_eoi();
    checks++;
    if ({bus.active_valid, bus.int_req} !== 2'b00) begin
      errors++; $display("FAIL basic_eoi: got %b exp 00", {bus.active_valid, bus.int_req});
    end
    tick(3);
  endtask

  task automatic test_simultaneous();
    write_mask(4'b1111);
    bus.irq_src = 4'b1010;
    tick(3);
    checks++;
    if (bus.pending !== 4'b1010) begin
      errors++; $display("FAIL simul_pend: got %b exp 1010", bus.pending);
    end
    tick();
    bus.irq_src = '0;
    checks++;
    if ({bus.int_req, bus.active_id} !== 3'b1_01) begin
      errors++; $display("FAIL simul_first: got %b exp 101", {bus.int_req, bus.active_id});
    end
    do_ack();
    checks++;
    if (bus.pending !== 4'b1000) begin
      errors++; $display("FAIL simul_ack_pend: got %b exp 1000", bus.pending);
    end
    do_eoi();  // edge n: IDLE for exactly one cycle
    checks++;
    if ({bus.int_req, bus.active_valid, bus.active_id} !== 4'b00_01) begin
      errors++; $display("FAIL simul_idle: got %b exp 0001", {bus.int_req, bus.active_valid, bus.active_id});
    end
    tick();    // n+1
    checks++;
    if ({bus.int_req, bus.active_valid, bus.active_id} !== 4'b11_11) begin
      errors++; $display("FAIL simul_second: got %b exp 1111", {bus.int_req, bus.active_valid, bus.active_id});
    end
    do_ack();
    do_eoi();
    checks++;
    if ({bus.pending, bus.active_valid} !== 5'b0000_0) begin
      errors++; $display("FAIL simul_done: got %b exp 00000", {bus.pending, bus.active_valid});
    end
    tick(2);
  endtask

  task automatic test_mask_gate();
    write_mask(4'b0000);
    bus.irq_src = 4'b0100;
    tick(5);
    bus.irq_src = '0;
    checks++;
    if ({bus.pending, bus.int_req} !== 5'b0100_0) begin
      errors++; $display("FAIL gate_masked: got %b exp 01000", {bus.pending, bus.int_req});
    end
    write_mask(4'b0100);  // edge w
    checks++;
    if ({bus.mask, bus.int_req} !== 5'b0100_0) begin
      errors++; $display("FAIL gate_write_edge: got %b exp 01000", {bus.mask, bus.int_req});
    end
    tick();               // w+1
    checks++;
    if ({bus.int_req, bus.active_id} !== 3'b1_10) begin
      errors++; $display("FAIL gate_req: got %b exp 110", {bus.int_req, bus.active_id});
    end
    write_mask(4'b0000);  // disabling the active source keeps the request
    tick();
    checks++;
    if ({bus.int_req, bus.active_valid} !== 2'b11) begin
      errors++; $display("FAIL gate_no_withdraw: got %b exp 11", {bus.int_req, bus.active_valid});
    end
    do_ack();
    do_eoi();
    tick(2);
  endtask

  task automatic test_set_wins();
    write_mask(4'b0001);
    bus.irq_src = 4'b0001;
    tick(4);
    bus.irq_src = '0;
    tick(3);              // still REQUEST, synchroniser drained
    checks++;
    if ({bus.int_req, bus.active_id} !== 3'b1_00) begin
      errors++; $display("FAIL setwin_req: got %b exp 100", {bus.int_req, bus.active_id});
    end
    bus.irq_src = 4'b0001;
    tick(2);              // k', k'+1: event pulse now live
    do_ack();             // edge k'+2 clears and sets pending[0] together
    bus.irq_src = '0;
    checks++;
    if ({bus.int_req, bus.pending} !== 5'b0_0001) begin
      errors++; $display("FAIL setwin_pend: got %b exp 00001", {bus.int_req, bus.pending});
    end
    do_eoi();
    tick();
    checks++;
    if ({bus.int_req, bus.active_valid, bus.active_id} !== 4'b11_00) begin
      errors++; $display("FAIL setwin_rereq: got %b exp 1100", {bus.int_req, bus.active_valid, bus.active_id});
    end
    do_ack();
    do_eoi();
    tick(2);
  endtask

  task automatic test_reset_mid();
    write_mask(4'b1111);
    bus.irq_src = 4'b0111;
    tick(4);
    bus.irq_src = '0;
    do_ack();
    checks++;
    if ({bus.pending, bus.active_valid, bus.int_req} !== 6'b0110_10) begin
      errors++; $display("FAIL rstmid_service: got %b exp 011010", {bus.pending, bus.active_valid, bus.int_req});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.int_req, bus.active_valid, bus.pending, bus.mask} !== 10'b0) begin
      errors++; $display("FAIL rstmid_async: got %b exp 0000000000", {bus.int_req, bus.active_valid, bus.pending, bus.mask});
    end
    tick(2);
    reset = 1'b1;
    tick(5);
    checks++;
    if ({bus.int_req, bus.pending} !== 5'b0) begin
      errors++; $display("FAIL rstmid_idle: got %b exp 00000", {bus.int_req, bus.pending});
    end
    bus.irq_src = 4'b0010;
    tick(5);
    bus.irq_src = '0;
    checks++;
    if ({bus.pending, bus.int_req} !== 5'b0010_0) begin
      errors++; $display("FAIL rstmid_nomask: got %b exp 00100", {bus.pending, bus.int_req});
    end
    write_mask(4'b0010);
    tick();
    checks++;
    if ({bus.int_req, bus.active_id} !== 3'b1_01) begin
      errors++; $display("FAIL rstmid_req: got %b exp 101", {bus.int_req, bus.active_id});
    end
    do_ack();
    do_eoi();
    tick(2);
  endtask

  task automatic test_spurious();
    write_mask(4'b0100);
    do_ack();             // ack in IDLE is ignored
    checks++;
    if ({bus.int_req, bus.active_valid} !== 2'b00) begin
      errors++; $display("FAIL spur_ack_idle: got %b exp 00", {bus.int_req, bus.active_valid});
    end
    bus.irq_src = 4'b0100;
    tick(4);
    bus.irq_src = '0;
    do_eoi();             // eoi in REQUEST is ignored
    tick(3);
    checks++;
    if ({bus.int_req, bus.active_valid, bus.active_id, bus.pending} !== 8'b11_10_0100) begin
      errors++; $display("FAIL spur_eoi_req: got %b exp 11100100", {bus.int_req, bus.active_valid, bus.active_id, bus.pending});
    end
    do_ack();
    checks++;
    if ({bus.int_req, bus.active_valid, bus.pending} !== 6'b01_0000) begin
      errors++; $display("FAIL spur_ack: got %b exp 010000", {bus.int_req, bus.active_valid, bus.pending});
    end
    do_ack();             // ack in SERVICE is ignored
    do_eoi();
    checks++;
    if ({bus.int_req, bus.active_valid} !== 2'b00) begin
      errors++; $display("FAIL spur_eoi: got %b exp 00", {bus.int_req, bus.active_valid});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_mask_gate();
    test_set_wins();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
